// File: rtl/meteor_spawn_scheduler.sv
//------------------------------------------------------------------------------
// meteor_spawn_scheduler : frame-paced meteor launcher with valid/ready payload
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module meteor_spawn_scheduler #(
  parameter int NUM_SLOTS       = 8,
  parameter int SPAWN_INTERVAL  = 30,
  parameter int MIN_INTERVAL    = 10,
  parameter int SPAWNS_PER_STEP = 8,
  parameter int SCREEN_W        = 640,
  parameter int MIN_SPEED       = 1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         enable,
  input  logic                         frame_tick,
  input  logic [9:0]                   rand_pos,
  input  logic [2:0]                   rand_xs,
  input  logic [2:0]                   rand_ys,
  input  logic                         rand_sign,
  input  logic [NUM_SLOTS-1:0]         slot_active,
  input  logic                         spawn_ready,
  output logic                         spawn_valid,
  output logic [$clog2(NUM_SLOTS)-1:0] spawn_slot,
  output logic [9:0]                   spawn_x,
  output logic [3:0]                   spawn_dx,
  output logic [2:0]                   spawn_dy,
  output logic [5:0]                   cur_interval,
  output logic [15:0]                  spawn_count
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);

  localparam logic [5:0]  c_spawn_iv  = 6'(SPAWN_INTERVAL);
  localparam logic [5:0]  c_min_iv    = 6'(MIN_INTERVAL);
  localparam logic [9:0]  c_screen_w  = 10'(SCREEN_W);
  localparam logic [2:0]  c_min_speed = 3'(MIN_SPEED);
  localparam logic [15:0] c_step_mask = 16'(SPAWNS_PER_STEP - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SELECT = 2'd2,
    S_OFFER  = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [5:0]        r_frame_cnt, w_frame_cnt_nxt;
  logic [5:0]        r_cur_interval;
  logic [15:0]       r_spawn_count;
  logic              r_valid;
  logic [SLOT_W-1:0] r_slot;
  logic [9:0]        r_x;
  logic [3:0]        r_dx;
  logic [2:0]        r_dy;

  logic              w_free_found;
  logic [SLOT_W-1:0] w_free_idx;
  logic              w_load;
  logic              w_accept;
  logic [9:0]        w_x;
  logic [3:0]        w_dx;
  logic [2:0]        w_dy;
  logic [15:0]       w_count_inc;

  // Descending scan so the lowest free index is the last one written.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_active[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = SLOT_W'(i);
      end
    end
  end

  assign w_x         = (rand_pos < c_screen_w) ? rand_pos : rand_pos - c_screen_w;
  assign w_dx        = rand_sign ? (4'd0 - {1'b0, rand_xs}) : {1'b0, rand_xs};
  assign w_dy        = (rand_ys < c_min_speed) ? c_min_speed : rand_ys;
  assign w_count_inc = r_spawn_count + 16'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_frame_cnt_nxt = r_frame_cnt;
    w_load          = 1'b0;
    w_accept        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt     = S_WAIT;
          w_frame_cnt_nxt = '0;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
        end else if (frame_tick) begin
          if (r_frame_cnt == r_cur_interval - 6'd1) w_state_nxt = S_SELECT;
          else                                      w_frame_cnt_nxt = r_frame_cnt + 6'd1;
        end
      end
      S_SELECT: begin
        if (w_free_found) begin
          w_load      = 1'b1;
          w_state_nxt = S_OFFER;
        end else begin
          // Park one tick short of terminal so the very next tick retries.
          w_state_nxt     = S_WAIT;
          w_frame_cnt_nxt = r_cur_interval - 6'd1;
        end
      end
      S_OFFER: begin
        if (spawn_ready) begin
          w_accept        = 1'b1;
          w_state_nxt     = S_WAIT;
          w_frame_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_valid        <= 1'b0;
      r_slot         <= '0;
      r_x            <= '0;
      r_dx           <= '0;
      r_dy           <= '0;
      r_cur_interval <= c_spawn_iv;
      r_spawn_count  <= '0;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_slot  <= w_free_idx;
        r_x     <= w_x;
        r_dx    <= w_dx;
        r_dy    <= w_dy;
      end
      if (w_accept) begin
        r_valid       <= 1'b0;
        r_spawn_count <= w_count_inc;
        if (((w_count_inc & c_step_mask) == 16'd0) && (r_cur_interval > c_min_iv))
          r_cur_interval <= r_cur_interval - 6'd1;
      end
    end
  end

  assign spawn_valid  = r_valid;
  assign spawn_slot   = r_slot;
  assign spawn_x      = r_x;
  assign spawn_dx     = r_dx;
  assign spawn_dy     = r_dy;
  assign cur_interval = r_cur_interval;
  assign spawn_count  = r_spawn_count;

endmodule

`default_nettype wire

// File: tb/tb_meteor_spawn_scheduler.sv
//------------------------------------------------------------------------------
// tb_meteor_spawn_scheduler : randomized bench against a transaction-level model
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_meteor_spawn_scheduler;

  localparam int NUM_SLOTS       = 8;
  localparam int SPAWN_INTERVAL  = 30;
  localparam int MIN_INTERVAL    = 10;
  localparam int SPAWNS_PER_STEP = 8;
  localparam int SCREEN_W        = 640;
  localparam int MIN_SPEED       = 1;

  logic        Clk = 1'b0;
  logic        Reset, enable, frame_tick, rand_sign, spawn_ready;
  logic [9:0]  rand_pos;
  logic [2:0]  rand_xs, rand_ys;
  logic [7:0]  slot_active;
  logic        spawn_valid;
  logic [2:0]  spawn_slot;
  logic [9:0]  spawn_x;
  logic [3:0]  spawn_dx;
  logic [2:0]  spawn_dy;
  logic [5:0]  cur_interval;
  logic [15:0] spawn_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;

  meteor_spawn_scheduler #(
    .NUM_SLOTS(NUM_SLOTS), .SPAWN_INTERVAL(SPAWN_INTERVAL), .MIN_INTERVAL(MIN_INTERVAL),
    .SPAWNS_PER_STEP(SPAWNS_PER_STEP), .SCREEN_W(SCREEN_W), .MIN_SPEED(MIN_SPEED)
  ) dut (
    .Clk(Clk), .Reset(Reset), .enable(enable), .frame_tick(frame_tick),
    .rand_pos(rand_pos), .rand_xs(rand_xs), .rand_ys(rand_ys), .rand_sign(rand_sign),
    .slot_active(slot_active), .spawn_ready(spawn_ready), .spawn_valid(spawn_valid),
    .spawn_slot(spawn_slot), .spawn_x(spawn_x), .spawn_dx(spawn_dx), .spawn_dy(spawn_dy),
    .cur_interval(cur_interval), .spawn_count(spawn_count)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Interval in force after c accepted spawns.
  function automatic int model_iv(input int c);
    int v;
    v = SPAWN_INTERVAL - c / SPAWNS_PER_STEP;
    return (v < MIN_INTERVAL) ? MIN_INTERVAL : v;
  endfunction

  function automatic logic [9:0] model_x(input logic [9:0] p);
    int v;
    v = int'(p);
    if (v >= SCREEN_W) v = v - SCREEN_W;
    return 10'(v);
  endfunction

  function automatic logic [3:0] model_dx(input logic [2:0] xs, input logic s);
    int v;
    v = s ? -int'(xs) : int'(xs);
    return 4'(v);
  endfunction

  function automatic logic [2:0] model_dy(input logic [2:0] ys);
    return (int'(ys) < MIN_SPEED) ? 3'(MIN_SPEED) : ys;
  endfunction

  function automatic int model_slot(input logic [7:0] a);
    for (int i = 0; i < NUM_SLOTS; i++) if (!a[i]) return i;
    return -1;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic noise();
    rand_pos  = 10'($urandom);
    rand_xs   = 3'($urandom);
    rand_ys   = 3'($urandom);
    rand_sign = 1'($urandom);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 1)) begin
        noise();
        step();
        check_eq(tag, spawn_valid, 0);
      end
      frame_tick = 1'b1;
      noise();
      step();
      frame_tick = 1'b0;
      check_eq(tag, spawn_valid, 0);
    end
  endtask

  // Starts with the scheduler counting from zero; ends one cycle after the handshake.
  task automatic run_spawn(input logic [9:0] pos, input logic [2:0] xs, input logic [2:0] ys,
                           input logic sgn, input logic [7:0] act, input bit full_first,
                           input int hold, input bit early, input bit rst_offer);
    int iv;
    int es;
    logic [9:0] ex;
    logic [3:0] edx;
    logic [2:0] edy;
    iv  = model_iv(exp_count);
    es  = model_slot(act);
    ex  = model_x(pos);
    edx = model_dx(xs, sgn);
    edy = model_dy(ys);
    check_eq("interval_before", cur_interval, iv);
    ticks(iv - 1, "valid_before_terminal");
    spawn_ready = early;
    frame_tick  = 1'b1;
    step();
    frame_tick = 1'b0;
    check_eq("select_cycle_valid", spawn_valid, 0);
    if (full_first) begin
      slot_active = 8'hFF;
      noise();
      step();
      check_eq("full_bank_valid", spawn_valid, 0);
      repeat (2) begin
        noise();
        step();
        check_eq("full_bank_wait_valid", spawn_valid, 0);
      end
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check_eq("retry_select_valid", spawn_valid, 0);
    end
    slot_active = act;
    rand_pos = pos; rand_xs = xs; rand_ys = ys; rand_sign = sgn;
    step();
    check_eq("offer_valid", spawn_valid, 1);
    check_eq("offer_slot", spawn_slot, es);
    check_eq("offer_x", spawn_x, ex);
    check_eq("offer_dx", spawn_dx, edx);
    check_eq("offer_dy", spawn_dy, edy);
    if (rst_offer) begin
      #2 Reset = 1'b1;
      #1;
      check_eq("rst_valid", spawn_valid, 0);
      check_eq("rst_interval", cur_interval, SPAWN_INTERVAL);
      check_eq("rst_count", spawn_count, 0);
      check_eq("rst_x", spawn_x, 0);
      #1 Reset = 1'b0;
      exp_count = 0;
      spawn_ready = 1'b0;
      step();
      return;
    end
    for (int h = 0; h < hold; h++) begin
      spawn_ready = 1'b0;
      enable      = 1'($urandom);
      slot_active = 8'($urandom);
      frame_tick  = 1'($urandom);
      noise();
      step();
      frame_tick = 1'b0;
      check_eq("hold_valid", spawn_valid, 1);
      check_eq("hold_slot", spawn_slot, es);
      check_eq("hold_x", spawn_x, ex);
      check_eq("hold_dx", spawn_dx, edx);
      check_eq("hold_dy", spawn_dy, edy);
      check_eq("hold_count", spawn_count, exp_count);
    end
    enable      = 1'b1;
    spawn_ready = 1'b1;
    step();
    spawn_ready = 1'b0;
    exp_count++;
    check_eq("accept_valid_drop", spawn_valid, 0);
    check_eq("accept_count", spawn_count, exp_count);
    check_eq("accept_interval", cur_interval, model_iv(exp_count));
  endtask

  initial begin
    logic [7:0] a;
    Reset = 1'b1; enable = 1'b0; frame_tick = 1'b0; spawn_ready = 1'b0;
    rand_pos = '0; rand_xs = '0; rand_ys = '0; rand_sign = 1'b0; slot_active = '0;
    repeat (3) @(posedge Clk);
    #1;
    check_eq("reset_valid", spawn_valid, 0);
    check_eq("reset_slot", spawn_slot, 0);
    check_eq("reset_x", spawn_x, 0);
    check_eq("reset_dx", spawn_dx, 0);
    check_eq("reset_dy", spawn_dy, 0);
    check_eq("reset_interval", cur_interval, SPAWN_INTERVAL);
    check_eq("reset_count", spawn_count, 0);
    Reset = 1'b0;
    step();
    enable = 1'b1;
    step();

    // Basic spawn with ready held high ahead of valid.
    run_spawn(10'd700, 3'd5, 3'd0, 1'b1, 8'h00, 1'b0, 0, 1'b1, 1'b0);
    check_eq("basic_count", spawn_count, 1);

    // Long back-pressure.
    run_spawn(10'd123, 3'd6, 3'd4, 1'b0, 8'h0F, 1'b0, 20, 1'b0, 1'b0);

    // Full bank, then slot 5 frees up.
    run_spawn(10'd300, 3'd2, 3'd7, 1'b1, 8'hDF, 1'b1, 1, 1'b0, 1'b0);

    // Edge payloads.
    run_spawn(10'd639, 3'd3, 3'd2, 1'b0, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    run_spawn(10'd640, 3'd0, 3'd1, 1'b1, 8'h03, 1'b0, 0, 1'b0, 1'b0);

    // Dropping enable mid-count restarts the frame count.
    ticks(12, "en_wait_valid");
    enable = 1'b0;
    step();
    repeat (5) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check_eq("idle_valid", spawn_valid, 0);
    end
    enable = 1'b1;
    step();
    run_spawn(10'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 8'h00, 1'b0, 0, 1'b0, 1'b0);

    while (exp_count < 180) begin
      a = 8'($urandom);
      a[$urandom_range(0, 7)] = 1'b0;
      run_spawn(10'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), a,
                1'($urandom_range(0, 15) == 0), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'b0);
      if (exp_count == 8)   check_eq("interval_after_8", cur_interval, 29);
      if (exp_count >= 168) check_eq("interval_floor", cur_interval, 10);
    end

    // Reset while offering, then resume from a clean state.
    run_spawn(10'd50, 3'd1, 3'd1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1);
    run_spawn(10'd900, 3'd7, 3'd5, 1'b1, 8'hFE, 1'b0, 2, 1'b0, 1'b0);
    check_eq("post_reset_count", spawn_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
